// File: rtl/seq_gen_pkg.sv
// Shared definitions for the framed serial transmitter (sequence_generator).
// Frame: PREAMBLE_PAT (sent MSB-first), payload MSB-first, then optional even parity.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        PARITY   = 2'd3
    } state_t;

    localparam int          PREAMBLE_W   = 4;
    localparam logic [3:0]  PREAMBLE_PAT = 4'b1010;

endpackage

// File: rtl/sequence_generator.sv
// Framed serial transmitter. It emits one bit per clock and feeds the 1010 detector.
// A payload is accepted over a load/ready handshake. The block then sends
// 1010, the payload MSB-first, and an optional even-parity bit.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   data_in    - payload word, sampled only when load && ready
//   load       - payload valid
//   ready      - registered; high in IDLE and during the last bit of a frame
//   out        - registered serial bit (0 when idle)
//   out_valid  - registered; out carries a frame bit
//   frame_done - registered; high during the last bit of each frame
module sequence_generator
    import seq_gen_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              ready,
    output logic              out,
    output logic              out_valid,
    output logic              frame_done
);

    localparam int CW = $clog2((DATA_W > PREAMBLE_W) ? DATA_W : PREAMBLE_W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(PREAMBLE_W - 1);
    localparam logic [CW-1:0] CNT_DATA = CW'(DATA_W - 1);

    state_t                  state;
    logic [CW-1:0]           cnt;     // bits left in the current state after the one on out
    logic [DATA_W-1:0]       shreg;
    logic [PREAMBLE_W-1:0]   pre_sh;
    logic                    par;

    wire accept = load && ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            pre_sh     <= '0;
            par        <= 1'b0;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            ready      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            ready      <= 1'b0;
            if (accept) begin
                // Accept is possible only in IDLE or on the last bit, so this
                // also covers the gapless back-to-back case.
                state     <= PREAMBLE;
                cnt       <= CNT_PRE;
                shreg     <= data_in;
                par       <= ^data_in;
                out       <= PREAMBLE_PAT[PREAMBLE_W-1];
                pre_sh    <= PREAMBLE_PAT << 1;
                out_valid <= 1'b1;
            end else begin
                case (state)
                    PREAMBLE: begin
                        if (cnt != '0) begin
                            cnt    <= cnt - CNT_ONE;
                            out    <= pre_sh[PREAMBLE_W-1];
                            pre_sh <= pre_sh << 1;
                        end else begin
                            state <= DATA;
                            cnt   <= CNT_DATA;
                            out   <= shreg[DATA_W-1];
                            shreg <= shreg << 1;
                            // A one-bit payload without parity makes the first
                            // data bit the last bit of the frame.
                            if (DATA_W == 1 && !PARITY_EN) begin
                                ready      <= 1'b1;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (cnt != '0) begin
                            cnt   <= cnt - CNT_ONE;
                            out   <= shreg[DATA_W-1];
                            shreg <= shreg << 1;
                            if (cnt == CNT_ONE && !PARITY_EN) begin
                                ready      <= 1'b1;
                                frame_done <= 1'b1;
                            end
                        end else if (PARITY_EN) begin
                            state      <= PARITY;
                            out        <= par;
                            ready      <= 1'b1;
                            frame_done <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            out       <= 1'b0;
                            out_valid <= 1'b0;
                            ready     <= 1'b1;
                        end
                    end
                    default: begin  // IDLE, or PARITY finishing without a new load
                        state     <= IDLE;
                        cnt       <= '0;
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        ready     <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
